neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
// Time-multiplexed controller for one dense neuron (N_IN weights + bias, e.g. enc2).
// Accepts an input vector via valid/ready and steps a weight-select index through the
// combinational weight bank (w0..w15/bias), one weight per cycle, into a single MAC.
// Adds the bias, rescales, saturates, applies optional ReLU, and returns one DATA_WIDTH
// result via valid/ready. Sits between the layer input buffer and the next layer.
// PARAMETERS
// DATA_WIDTH  16  signed fixed-point word width (inputs, weights, bias, result)
// FRAC_BITS   10  fractional bits of every word (Q6.10)
// N_IN        16  inputs/weights per neuron; >=2
// ACC_WIDTH   40  signed accumulator width; >= 2*DATA_WIDTH+$clog2(N_IN)+1
// RELU        1   1: clamp negative results to 0; 0: pass signed result
// PORTS
// clk        in   1                   clock, all state on rising edge
// rst        in   1                   synchronous, active-high reset
// in_valid   in   1                   input vector valid
// in_ready   out  1                   block can accept a vector
// in_vec     in   N_IN*DATA_WIDTH     x[k] = in_vec[k*DATA_WIDTH +: DATA_WIDTH]
// w_sel      out  $clog2(N_IN)        weight index driven to the weight-bank mux
// w_data     in   DATA_WIDTH          weight selected by w_sel (same-cycle combinational)
// bias       in   DATA_WIDTH          neuron bias, sampled only in FINISH
// out_valid  out  1                   result valid
// out_ready  in   1                   downstream accepts result
// out_data   out  DATA_WIDTH          signed Q-format result
// busy       out  1                   high in MAC/FINISH/OUT
// BEHAVIOUR
// - Reset: state=IDLE, acc=0, k=0, x_reg=0, out_data=0, out_valid=0, busy=0, w_sel=0.
// - in_ready = (state==IDLE) & ~rst (combinational); in_ready is never high outside IDLE.
// - FSM: IDLE -> MAC on in_valid&in_ready. The edge captures in_vec into x_reg,
//   clears acc and sets k=0.
// - MAC (exactly N_IN cycles): w_sel=k; acc += sext(x_reg[k]*w_data) (full 2*DATA_WIDTH
//   signed product, no rounding); k++. When k==N_IN-1 -> FINISH.
// - FINISH (1 cycle): s = acc + (sext(bias) <<< FRAC_BITS);
//   r = s >>> FRAC_BITS (arithmetic shift, truncation toward -inf);
//   saturate r to [-2^(DW-1), 2^(DW-1)-1]; if RELU and r<0 then r=0.
//   Register r into out_data, set out_valid=1 -> OUT.
// - OUT: out_data and out_valid are held stable until out_valid&out_ready.
//   On that edge: out_valid=0 -> IDLE. There is no accept in the same cycle.
// - Latency: out_valid rises N_IN+1 cycles after the accept edge.
//   Max throughput: one vector per N_IN+3 cycles.
// - w_sel=0 outside MAC. in_vec, in_valid and w_data are don't-care outside their use cycles.
// - busy = (state!=IDLE).
// - Reset mid-operation (any state): abort and discard acc. out_valid is 0 from the next
//   edge. No partial result is ever emitted.
// - in_valid while busy is ignored (not queued).
// - The accumulator never wraps for legal parameters. Overflow is handled only by the
//   final saturation.
// STRUCTURE
// - Shared package (fixed-point constants): DATA_WIDTH, FRAC_BITS, ACC_WIDTH, Q_ONE=1<<FRAC_BITS,
//   Q_MAX/Q_MIN; state enum {IDLE,MAC,FINISH,OUT}.
// - One sub-module: fxp_sat_relu, combinational (ACC_WIDTH in -> shift, saturate, ReLU ->
//   DATA_WIDTH out). It is reused by other neuron sequencers.
// - Top: FSM, k counter, x_reg, acc, signed multiplier, output register.
// TESTING (bench drives w_data from enc2 weight bank via w_sel; bias=0xfe4d)
// 1 All x=0x0000, RELU=0 -> out_data=0xfe4d. With RELU=1 -> 0x0000.
//   out_valid exactly 17 cycles after accept.
// 2 All x=0x0400 (1.0), RELU=0 -> sum(w)=3110, +bias -435 -> out_data=0x0A73.
// 3 Stub bank all w=0x7fff, x=0x7fff, bias=0x7fff -> out_data=0x7fff.
//   With w=0x8000 and RELU=0 -> 0x8000.
// 4 Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout.
//   Release -> one handshake, in_ready=1 the following cycle.
// 5 rst pulsed during MAC at k=7 -> no out_valid ever for that vector. in_ready=1 after
//   reset deasserts. Next vector (test 2) yields 0x0A73.
// 6 Back-to-back vectors with in_valid and out_ready held high -> accepts spaced 19
//   cycles apart, w_sel sequence 0..15 each pass.

Source files
------------

// File: rtl/neuron_mac_seq_pkg.sv
// Shared fixed-point constants and FSM encoding for the neuron MAC sequencers.
package neuron_mac_seq_pkg;

  // Default word geometry: signed Q6.10 words, 16-input neuron.
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 10;
  localparam int N_IN       = 16;
  localparam int ACC_WIDTH  = 40;

  // Handy Q-format constants for the default word width.
  localparam logic signed [DATA_WIDTH-1:0] Q_ONE = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Sequencer states, kept as plain constants so older tools can read them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_MAC    = 2'd1;
  localparam state_t ST_FINISH = 2'd2;
  localparam state_t ST_OUT    = 2'd3;

  // Smallest accumulator that cannot wrap for n products of dw-bit words
  // plus a shifted bias term.
  function automatic int min_acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/neuron_mac_seq_fxp_sat_relu.sv
// fxp_sat_relu: combinational accumulator-to-word conversion.
// Drops FRAC_BITS fraction bits (floor), saturates to the signed word range
// and optionally clamps negative results to zero.
module fxp_sat_relu #(
  parameter int ACC_WIDTH  = 40,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int RELU       = 1
) (
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int SH_WIDTH = ACC_WIDTH - FRAC_BITS;

  localparam logic [DATA_WIDTH-1:0] WORD_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] WORD_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [SH_WIDTH-1:0]            shifted;
  logic [SH_WIDTH-DATA_WIDTH:0]   upper_bits;
  logic                           sign_bit;
  logic                           overflow;
  logic [DATA_WIDTH-1:0]          sat_val;
  logic                           unused_frac;

  // Taking the upper slice is an arithmetic right shift that truncates
  // toward minus infinity; the fraction bits are simply discarded.
  assign shifted     = acc_in[ACC_WIDTH-1:FRAC_BITS];
  assign unused_frac = ^acc_in[FRAC_BITS-1:0];
  assign sign_bit    = shifted[SH_WIDTH-1];

  // The value fits the word only if every bit from the word's sign bit up is
  // a copy of the sign.
  assign upper_bits = shifted[SH_WIDTH-1:DATA_WIDTH-1];
  assign overflow   = ~((&upper_bits) | (~|upper_bits));

  // Saturate toward the limit on the side of the true sign.
  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (overflow) begin
      sat_val = sign_bit ? WORD_MIN : WORD_MAX;
    end
  end

  // Optional rectifier; the sign of the saturated value equals the sign of
  // the unsaturated one, so the shifted sign bit can drive the clamp.
  generate
    if (RELU != 0) begin : g_relu
      assign data_out = sign_bit ? '0 : sat_val;
    end else begin : g_pass
      assign data_out = sat_val;
    end
  endgenerate

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed controller for one dense neuron.
// Captures an input vector, walks w_sel across the external weight bank one
// weight per cycle into a single MAC, adds the bias, rescales, saturates,
// optionally rectifies, and hands one word downstream via valid/ready.
module neuron_mac_seq #(
  parameter int DATA_WIDTH = neuron_mac_seq_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = neuron_mac_seq_pkg::FRAC_BITS,
  parameter int N_IN       = neuron_mac_seq_pkg::N_IN,
  parameter int ACC_WIDTH  = neuron_mac_seq_pkg::ACC_WIDTH,
  parameter int RELU       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*DATA_WIDTH-1:0]   in_vec,
  output logic [$clog2(N_IN)-1:0]      w_sel,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [DATA_WIDTH-1:0]        bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         busy
);

  import neuron_mac_seq_pkg::*;

  localparam int K_WIDTH = $clog2(N_IN);
  localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(N_IN - 1);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [K_WIDTH-1:0]      k_q, k_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   x_q [N_IN];
  logic [DATA_WIDTH-1:0]   x_d [N_IN];
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  // ------------------------------------------------------------------
  // Datapath nets
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   x_in [N_IN];
  logic [DATA_WIDTH-1:0]   x_cur;
  logic [PROD_WIDTH-1:0]   x_ext;
  logic [PROD_WIDTH-1:0]   w_ext;
  logic [PROD_WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    bias_ext;
  logic [ACC_WIDTH-1:0]    fin_sum;
  logic [DATA_WIDTH-1:0]   fin_word;
  logic                    accept;

  // Split the flat input bus into per-element words.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign x_in[gi] = in_vec[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Handshake and status outputs; in_ready is forced low while reset is held.
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // The weight bank is addressed only while multiplying; parked at 0 otherwise.
  assign w_sel = (state_q == ST_MAC) ? k_q : '0;

  // Full-precision signed product: both operands are sign-extended to the
  // product width so the low PROD_WIDTH bits of the multiply are exact.
  assign x_cur = x_q[k_q];
  assign x_ext = {{DATA_WIDTH{x_cur[DATA_WIDTH-1]}}, x_cur};
  assign w_ext = {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};
  assign prod  = x_ext * w_ext;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  // Bias is aligned to the product's Q-point (2*FRAC_BITS fraction bits)
  // by shifting it left by FRAC_BITS before the final add.
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}},
                     bias, {FRAC_BITS{1'b0}}};
  assign fin_sum  = acc_q + bias_ext;

  fxp_sat_relu #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .RELU       (RELU)
  ) u_sat (
    .acc_in   (fin_sum),
    .data_out (fin_word)
  );

  // Next-state logic: IDLE -> MAC (N_IN cycles) -> FINISH -> OUT -> IDLE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = x_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_FINISH;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_FINISH: begin
        out_data_d  = fin_word;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        // Result stays put until taken; the next vector is accepted only
        // after returning to IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: one RELU=0 and one RELU=1 instance
// share all inputs; expected words are queued at accept and compared at the
// output handshake.
module tb_neuron_mac_seq;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int FB = 10;
  // enc2-style weight bank; the weights sum to 3110 (raw Q6.10 units).
  localparam int ENC2 [N] = '{412, -157, 288, 75, -340, 501, 203, -96,
                              330, 148, -221, 467, 89, 612, -184, 983};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic [N*DW-1:0]   in_vec;
  logic [DW-1:0]     bias;
  logic [DW-1:0]     w_data0, w_data1;
  logic [3:0]        w_sel0, w_sel1;
  logic              in_ready0, in_ready1;
  logic              out_valid0, out_valid1;
  logic              busy0, busy1;
  logic [DW-1:0]     out_data0, out_data1;

  int bank_mode;

  function automatic logic [DW-1:0] bank_w(input int mode, input int idx);
    case (mode)
      1:       return 16'h7fff;
      2:       return 16'h8000;
      default: return DW'(ENC2[idx]);
    endcase
  endfunction

  always_comb w_data0 = bank_w(bank_mode, int'(w_sel0));
  always_comb w_data1 = bank_w(bank_mode, int'(w_sel1));

  neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_IN(N), .ACC_WIDTH(40), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
    .w_sel(w_sel0), .w_data(w_data0), .bias(bias), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_IN(N), .ACC_WIDTH(40), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
    .w_sel(w_sel1), .w_data(w_data1), .bias(bias), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    string         nm;
  } exp_t;

  exp_t sbq[$];
  exp_t cur_exp;
  exp_t pop_e;

  int acc_edge      = 0;
  int last_acc_edge = -1;
  int n_acc         = 0;
  int mon_idx       = 0;
  bit win_active    = 1'b0;
  bit chk_spacing   = 1'b0;
  bit ov_prev       = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: exact integer arithmetic on the spec formula.
  function automatic logic [DW-1:0] model(input logic [N*DW-1:0] v, input int mode,
                                          input logic [DW-1:0] b, input bit relu);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      s += longint'($signed(v[k*DW +: DW])) * longint'($signed(bank_w(mode, k)));
    end
    s += longint'($signed(b)) * 1024;
    s = s >>> FB;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  // Monitor: w_sel stepping, accept bookkeeping, latency, output scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (win_active) begin
          mon_idx = cyc - acc_edge;
          if (mon_idx >= 0 && mon_idx < N) begin
            check("w_sel_step", 32'(w_sel0), 32'(mon_idx));
            check("w_sel_step_relu", 32'(w_sel1), 32'(mon_idx));
          end
        end
        if (in_ready0) check("w_sel_idle", 32'(w_sel0), 32'd0);
        if (in_valid && in_ready0) begin
          if (chk_spacing) begin
            if (last_acc_edge >= 0) check("accept_spacing", 32'(cyc + 1 - last_acc_edge), 32'd19);
            last_acc_edge = cyc + 1;
          end
          acc_edge   = cyc + 1;
          win_active = 1'b1;
          sbq.push_back(cur_exp);
          n_acc++;
        end
        if (out_valid0 && !ov_prev) check("latency", 32'(cyc - acc_edge), 32'd17);
        if (out_valid0 && out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got out_data=%h expected no output", out_data0);
          end else begin
            pop_e = sbq.pop_front();
            check({pop_e.nm, "_out"}, 32'(out_data0), 32'(pop_e.e0));
            check({pop_e.nm, "_out_relu"}, 32'(out_data1), 32'(pop_e.e1));
            check({pop_e.nm, "_valid_relu"}, 32'(out_valid1), 32'd1);
            $display("txn %s: out=%h relu_out=%h exp=%h/%h", pop_e.nm, out_data0, out_data1,
                     pop_e.e0, pop_e.e1);
          end
        end
      end
      ov_prev = out_valid0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [N*DW-1:0] v, input logic [DW-1:0] b, input int mode,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1, input string nm);
    int start;
    bit got;
    @(posedge clk);
    #1;
    in_vec    = v;
    bias      = b;
    bank_mode = mode;
    cur_exp   = '{e0, e1, nm};
    in_valid  = 1'b1;
    start     = n_acc;
    got       = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != start) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got no accept expected one within 60 cycles", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0 && in_ready0) done = 1'b1;
    end
    check({nm, "_drain"}, 32'(done), 32'd1);
  endtask

  typedef struct {
    int            mode;
    logic [DW-1:0] x;
    logic [DW-1:0] b;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    string         nm;
  } vec_t;

  localparam int NT = 7;
  vec_t tbl [NT];

  logic [N*DW-1:0] v;
  logic [N*DW-1:0] v_one;
  int   start_acc;
  bit   got;
  bit   seen;

  initial begin
    // mode, x (all elements), bias, expected RELU=0, expected RELU=1
    tbl[0] = '{0, 16'h0000, 16'hfe4d, 16'hfe4d, 16'h0000, "zero_x"};
    tbl[1] = '{0, 16'h0400, 16'hfe4d, 16'h0a73, 16'h0a73, "x_one"};
    tbl[2] = '{1, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, "sat_pos"};
    tbl[3] = '{2, 16'h7fff, 16'h7fff, 16'h8000, 16'h0000, "sat_neg"};
    tbl[4] = '{0, 16'hfc00, 16'hfe4d, 16'hf227, 16'h0000, "x_minus_one"};
    tbl[5] = '{0, 16'h0200, 16'hfe4d, 16'h0460, 16'h0460, "x_half"};
    tbl[6] = '{0, 16'h0001, 16'hfe4d, 16'hfe50, 16'h0000, "floor_neg"};

    v_one     = {N{16'h0400}};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_vec    = '0;
    bias      = '0;
    bank_mode = 0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 32'd0);
    check("rst_in_ready_relu", 32'(in_ready1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready0), 32'd1);
    check("reset_out_valid", 32'(out_valid0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_w_sel", 32'(w_sel0), 32'd0);
    check("reset_out_data", 32'(out_data0), 32'd0);
    check("reset_out_data_relu", 32'(out_data1), 32'd0);
    check("reset_busy_relu", 32'(busy1), 32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < NT; i++) begin
      v = {N{tbl[i].x}};
      send(v, tbl[i].b, tbl[i].mode, tbl[i].e0, tbl[i].e1, tbl[i].nm);
      wait_drain(tbl[i].nm);
    end

    // ---- random vectors against the integer model ----
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom_range(0, 65535));
      send(v, 16'hfe4d, 0, model(v, 0, 16'hfe4d, 1'b0), model(v, 0, 16'hfe4d, 1'b1), "rand");
      wait_drain("rand");
    end

    // ---- backpressure: result held while out_ready is low ----
    out_ready = 1'b0;
    send(v_one, 16'hfe4d, 0, 16'h0a73, 16'h0a73, "bp");
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid0) got = 1'b1;
    end
    check("bp_valid_rise", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    cur_exp  = '{16'h0a73, 16'h0a73, "bp_next"};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid0), 32'd1);
      check("bp_hold_data", 32'(out_data0), 32'h0a73);
      check("bp_in_ready_low", 32'(in_ready0), 32'd0);
      check("bp_busy", 32'(busy0), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_valid", 32'(out_valid0), 32'd1);
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready0), 32'd1);
    check("bp_valid_dropped", 32'(out_valid0), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("bp_next");

    // ---- reset in the middle of MAC at k=7 ----
    send(v_one, 16'hfe4d, 0, 16'h0a73, 16'h0a73, "rst_vec");
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (w_sel0 == 4'd7) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rst_k7_found", 32'(got), 32'd1);
    rst        = 1'b1;
    win_active = 1'b0;
    if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready0), 32'd0);
    check("midrst_in_ready_relu", 32'(in_ready1), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_w_sel", 32'(w_sel0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", 32'(in_ready0), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("midrst_no_partial", 32'(seen), 32'd0);
    send(v_one, 16'hfe4d, 0, 16'h0a73, 16'h0a73, "after_rst");
    wait_drain("after_rst");

    // ---- back-to-back vectors, in_valid and out_ready held high ----
    @(posedge clk);
    #1;
    chk_spacing   = 1'b1;
    last_acc_edge = -1;
    cur_exp       = '{16'h0a73, 16'h0a73, "b2b"};
    in_vec        = v_one;
    bias          = 16'hfe4d;
    bank_mode     = 0;
    out_ready     = 1'b1;
    start_acc     = n_acc;
    in_valid      = 1'b1;
    for (int i = 0; i < 100 && n_acc < start_acc + 3; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc - start_acc), 32'd3);
    wait_drain("b2b");
    chk_spacing = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
